// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell.
// Operands are shifted out LSB first, one bit per clock, with the carry held in a flop.
// A start/busy/done handshake frames each WIDTH-cycle operation.

// 1-bit full-adder cell: s = a^b^c, co = majority(a,b,c)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic fa_s, fa_co;
  logic c_msb_in;
  logic last_step;

  fa_cell u_fa (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .c (carry),
    .s (fa_s),
    .co(fa_co)
  );

  // On the MSB step the carry flop holds the carry into the MSB; it is consumed
  // on that same edge, so it needs no separate storage.
  assign last_step = (cnt == LAST);
  assign c_msb_in  = carry;

  // Sequencer: operand capture, serial stepping and registered result/handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            // Results publish only here, so a reset mid-run never exposes a partial sum.
            sum      <= {fa_s, s_sr[WIDTH-1:1]};
            cout     <= fa_co;
            overflow <= c_msb_in ^ fa_co;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // One-cycle done pulse, start is ignored here.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed table, held-start,
// mid-operation reset and randomized ops against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, overflow;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .sub     (sub),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {cout,sum} = a + (sub?~b:b) + (sub?1:cin); signed overflow when
  // both addends share a sign that the result does not.
  task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                       input logic isub, output logic [W-1:0] es, output logic ec,
                       output logic eo);
    logic [W-1:0] bb;
    int unsigned  full;
    bb   = isub ? ~ib : ib;
    full = int'(ia) + int'(bb) + (isub ? 1 : int'(icin));
    es   = W'(full);
    ec   = (full >> W) & 1;
    eo   = (ia[W-1] == bb[W-1]) && (es[W-1] != ia[W-1]);
  endtask

  // Runs one operation starting from an IDLE cycle (called just after a negedge)
  // and checks busy window, sum hold, done pulse and results.
  task automatic do_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub, input logic [W-1:0] es,
                       input logic ec, input logic eo);
    logic         bad;
    logic [W-1:0] held;
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    held = sum;
    @(negedge clk);
    start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || sum !== held) bad = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
    end
    chk({nm, ".busy_window"}, 32'(bad), 0);
    chk({nm, ".done"}, {30'd0, done, busy}, 32'b10);
    chk({nm, ".sum"}, 32'(sum), 32'(es));
    chk({nm, ".cout"}, 32'(cout), 32'(ec));
    chk({nm, ".ovf"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    chk({nm, ".done_clr"}, {30'd0, done, busy}, 0);
  endtask

  initial begin
    vec_t vecs[7];
    logic [W-1:0] es;
    logic ec, eo;
    int   ndone;
    logic bad;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.outs", {busy, done, cout, overflow, sum}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.no_start", {busy, done}, 0);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].es, vecs[i].ec, vecs[i].eo);
    end

    // start held high: one op accepted every W+2 cycles, operands scrambled while busy
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    ndone = 0;
    bad = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done !== ((n % 10) == 9)) bad = 1'b1;
      if (busy !== ((n % 10) >= 1 && (n % 10) <= 8)) bad = 1'b1;
      if (done === 1'b1) begin
        ndone++;
        chk($sformatf("held.sum%0d", ndone), {cout, overflow, sum}, 32'h02);
      end
      if (busy === 1'b1) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end else begin
        a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0;
      end
      if (n == 30) start = 1'b0;
    end
    chk("held.timing", 32'(bad), 0);
    chk("held.ndone", 32'(ndone), 3);
    @(negedge clk);
    chk("held.idle", {busy, done}, 0);

    // Reset during the 4th RUN cycle aborts without a done pulse
    a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.outs", {busy, done, cout, overflow, sum}, 0);
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) bad = 1'b1;
    end
    chk("abort.quiet", 32'(bad), 0);
    do_op("after_abort", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

    // Randomized ops against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, es, ec, eo);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs, es, ec, eo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
